// File: rtl/fq_pkg.sv
// Shared types and helpers for the fetch queue.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fq_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  // Instructions are word aligned, so the two low PC bits carry no information.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fq_ptr.sv
// Wrapping read/write pointer for the fetch queue ring buffer.
// Latency: the new pointer value is visible the cycle after inc_i/clr_i.
// Backpressure: none; the caller decides when to advance.
module fq_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Clear wins over increment; power-of-two depth makes the natural overflow the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer with branch-redirect flush; FQ_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle push-to-output (0 cycles through the bypass when FQ_BYPASS_EN is defined).
// Backpressure: in_ready drops when full regardless of out_ready; pushes while full are dropped and set sticky ovf.
module fetch_queue
  import fq_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  input  logic              out_ready,
  input  logic              flush,
  output logic [PTR_W:0]    count,
  output logic              ovf
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  fq_entry_t        mem_q [DEPTH];
  logic             empty, full, bypass, push, pop;

  // Handshake decode and output mux; flush suppresses both push and pop.
  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == FULL_CNT);
    bypass = 1'b0;
`ifdef FQ_BYPASS_EN
    bypass = empty & in_valid & out_ready & ~flush;
`endif
    in_ready  = ~full;
    // A bypassed word goes straight to decode, so it must not also be written.
    push      = in_valid & ~full & ~flush & ~bypass;
    pop       = ~empty & out_ready & ~flush;
    out_valid = ~empty | bypass;
    out_instr = NOP_INSTR;
    out_pc    = '0;
    if (bypass) begin
      out_instr = in_instr;
      out_pc    = align_pc(in_pc);
    end else if (!empty) begin
      out_instr = mem_q[rd_ptr].instr;
      out_pc    = mem_q[rd_ptr].pc;
    end
  end

  // Occupancy and sticky overflow next state.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q | (in_valid & full & ~flush);
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage is not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= '{instr: in_instr, pc: align_pc(in_pc)};
    end
  end

  fq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (pop),
    .clr_i (flush),
    .ptr_o (rd_ptr)
  );

  fq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (push),
    .clr_i (flush),
    .ptr_o (wr_ptr)
  );

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table for basic/alignment/bypass cases, scoreboard for multi-cycle sequences.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on the following negedge.
// Backpressure: exercised through out_ready patterns, fill-to-full and flush.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        rdy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    int          e_cnt;
    logic        e_ir;
    logic        e_ovf;
  } vec_t;

  exp_t sb[$];
  int   mcount;
  logic movf;
  vec_t vecs[12];

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                              input logic rdy, input logic fl, input logic e_ov,
                              input logic [31:0] e_ins, input logic [31:0] e_pc,
                              input int e_cnt, input logic e_ir, input logic e_ovf);
    vec_t r;
    r.v = v; r.ins = ins; r.pc = pc; r.rdy = rdy; r.fl = fl;
    r.e_ov = e_ov; r.e_ins = e_ins; r.e_pc = e_pc;
    r.e_cnt = e_cnt; r.e_ir = e_ir; r.e_ovf = e_ovf;
    return r;
  endfunction

  // One cycle against the scoreboard model. Called at posedge+1.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    logic byp;
    exp_t e;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    #4;
    byp = 1'b0;
`ifdef FQ_BYPASS_EN
    byp = (mcount == 0) && v && rdy && !fl;
`endif
    chk("out_valid", 32'(out_valid), 32'((mcount != 0) || byp));
    chk("count", 32'(count), 32'(mcount));
    chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
    chk("ovf", 32'(ovf), 32'(movf));
    if (byp) begin
      chk("byp_instr", out_instr, ins);
      chk("byp_pc", out_pc, pc & 32'hFFFF_FFFC);
    end else if (mcount != 0) begin
      chk("head_instr", out_instr, sb[0].instr);
      chk("head_pc", out_pc, sb[0].pc);
    end else begin
      chk("idle_instr", out_instr, 32'h0);
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (v && mcount == DEPTH) movf = 1'b1;
      if (mcount != 0 && rdy) void'(sb.pop_front());
      if (v && mcount != DEPTH && !byp) begin
        e.instr = ins;
        e.pc    = pc & 32'hFFFF_FFFC;
        sb.push_back(e);
      end
    end
    mcount = sb.size();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0;
    mcount = 0; movf = 1'b0;

    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 32'h1111_0000, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'h1111_0000, 32'h100, 1, 1, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 1, 32'h1111_0000, 32'h100, 1, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[5]  = mk(1, 32'hAAAA_0003, 32'h103, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 1, 32'hAAAA_0003, 32'h100, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef FQ_BYPASS_EN
    vecs[8]  = mk(1, 32'h22, 32'h202, 1, 0, 1, 32'h22, 32'h200, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
`else
    vecs[8]  = mk(1, 32'h22, 32'h202, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 32'h22, 32'h200, 1, 1, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 1, 32'h22, 32'h200, 1, 1, 0);
`endif
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    // Vector table: reset idle, single push/pop, PC alignment, bypass or its absence.
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].v; in_instr = vecs[i].ins; in_pc = vecs[i].pc;
      out_ready = vecs[i].rdy; flush = vecs[i].fl;
      #4;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_instr", i), out_instr, vecs[i].e_ins);
      chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
      @(posedge clk);
      #1;
    end

    // Fill past full: fifth push is dropped and sets ovf; drain in order.
    for (int i = 0; i < 5; i++) cyc(1, 32'h3000_0000 + 32'(i), 32'h300 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    chk("after_fill_ovf", 32'(ovf), 32'h1);

    // Steady push+pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) cyc(1, 32'h4000_0000 + 32'(i), 32'h400 + 32'(4 * i), 0, 0);
    for (int i = 2; i < 12; i++) cyc(1, 32'h4000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

    // Flush at occupancy 3 with a same-cycle push; nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) cyc(1, 32'h5000_0000 + 32'(i), 32'h500 + 32'(4 * i), 0, 0);
    cyc(1, 32'hDEAD_BEEF, 32'h5F0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    chk("flush_ovf_kept", 32'(ovf), 32'h1);

    // Asynchronous reset mid-operation empties the queue without a clock edge.
    for (int i = 0; i < 2; i++) cyc(1, 32'h6000_0000 + 32'(i), 32'h600, 0, 0);
    in_valid = 0; out_ready = 0; flush = 0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_ovf", 32'(ovf), 32'h0);
    #1 reset = 1'b0;
    sb.delete(); mcount = 0; movf = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 32'h7000_0000, 32'h707, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
